f01_sweep_ctrl: RTL

Sequencer that exhaustively exercises the `f01` majority-style gate (`x = a & (b | c)`) in hardware. On `start` it steps all eight `{a,b,c}` input vectors through an internal `f01` instance, holding each vector for a programmable settle time. It captures the output into an 8-bit truth-table register and compares it against a caller-supplied expected table. It sits beside the `f01` datapath as its self-test controller, replacing the hand-sequenced stimulus of the G04xx testbenches with a synthesizable, handshaked block.

---
 rtl/f01_pkg.sv | 17 +
 rtl/f01.sv | 11 +
 rtl/f01_sweep_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/f01_pkg.sv
// Shared types and constants for the f01 gate and its sweep controller.
package f01_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  localparam int unsigned F01_NVEC   = 8;
  localparam int unsigned F01_VEC_W  = $clog2(F01_NVEC);
  localparam int unsigned F01_CNT_W  = 4;
  localparam logic [F01_NVEC-1:0] F01_GOLDEN = 8'hE0;

endpackage : f01_pkg

// File: rtl/f01.sv
// f01 gate: x = a & (b | c), purely combinational.
module f01 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x
);

  assign x = a & (b | c);

endmodule : f01

// File: rtl/f01_sweep_ctrl.sv
// Self-test sequencer: steps all eight {a,b,c} vectors through f01, captures
// the truth table and compares it with a caller-supplied expectation.
module f01_sweep_ctrl
  import f01_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [F01_NVEC-1:0]  expected,
  output logic                 busy,
  output logic                 done,
  output logic [F01_VEC_W-1:0] vec,
  output logic [F01_NVEC-1:0]  result,
  output logic [F01_NVEC-1:0]  mismatch,
  output logic                 pass
);

  localparam logic [F01_CNT_W-1:0] CNT_LOAD = F01_CNT_W'(SETTLE - 1);
  localparam logic [F01_VEC_W-1:0] VEC_LAST = F01_VEC_W'(F01_NVEC - 1);

  sweep_state_e          state_q, state_d;
  logic [F01_CNT_W-1:0]  cnt_q, cnt_d;
  logic [F01_VEC_W-1:0]  vec_q, vec_d;
  logic [F01_NVEC-1:0]   result_q, result_d;
  logic [F01_NVEC-1:0]   exp_q, exp_d;
  logic [F01_NVEC-1:0]   mismatch_q, mismatch_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  f01_x;

  // Gate under test, driven straight from the current vector.
  f01 u_f01 (
    .a (vec_q[2]),
    .b (vec_q[1]),
    .c (vec_q[0]),
    .x (f01_x)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      result_q   <= '0;
      exp_q      <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      result_q   <= result_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; results stay held after a sweep until the next start.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    result_d   = result_q;
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = ST_APPLY;
          exp_d      = expected;
          vec_d      = '0;
          result_d   = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
        end
      end
      ST_APPLY: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - F01_CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        result_d[vec_q] = f01_x;
        if (vec_q == VEC_LAST) begin
          state_d    = ST_FINISH;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mismatch_d = result_d ^ exp_q;
          pass_d     = (mismatch_d == '0);
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_q + F01_VEC_W'(1);
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign vec      = vec_q;
  assign result   = result_q;
  assign mismatch = mismatch_q;
  assign pass     = pass_q;

endmodule : f01_sweep_ctrl
